// File: rtl/oadc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : oadc_capture_ctrl
// Brief    : OpenADC capture sequencer: circular pre-trigger buffer, qualified
//            trigger edge, programmable post-trigger length, streamed readout.
// Revision : 1.0 - initial release
// ============================================================================
module oadc_capture_ctrl #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              sample_en,
    input  logic              adc_or,
    input  logic              trig_in,
    input  logic              trig_pol,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] post_cnt,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic [2:0]        state,
    output logic              or_seen,
    output logic [ADDR_W-1:0] trig_addr
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_fill = 3'd1;
    localparam logic [2:0] c_st_wait = 3'd2;
    localparam logic [2:0] c_st_post = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;
    localparam logic [2:0] c_st_read = 3'd5;

    localparam logic [ADDR_W-1:0] c_one  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_ones = {ADDR_W{1'b1}};

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_post_p;
    logic [ADDR_W-1:0] r_trig_addr;
    logic              r_trig_pend;
    logic              r_trig_prev;
    logic              r_or_seen;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_rd_last;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_edge;
    logic              w_capturing;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_post_p;
    logic [ADDR_W-1:0] w_pre_m1;

    assign w_edge      = trig_pol ? (~trig_in & r_trig_prev) : (trig_in & ~r_trig_prev);
    assign w_capturing = (r_state == c_st_fill) || (r_state == c_st_wait) ||
                         (r_state == c_st_post);
    assign w_wr_en     = sample_en & w_capturing & ~abort;
    assign w_post_p    = (post_cnt == '0) ? c_one : post_cnt;
    // Index of the last pre-trigger write: DEPTH - P - 1, wrapping naturally.
    assign w_pre_m1    = c_ones - r_post_p;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= adc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_post_p    <= '0;
            r_trig_addr <= '0;
            r_trig_pend <= 1'b0;
            r_trig_prev <= 1'b0;
            r_or_seen   <= 1'b0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
        end else begin
            r_trig_prev <= trig_in;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;

            if (w_wr_en && adc_or) begin
                r_or_seen <= 1'b1;
            end

            if (abort) begin
                r_state <= c_st_idle;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (arm) begin
                            r_state     <= c_st_fill;
                            r_wr_ptr    <= '0;
                            r_cnt       <= '0;
                            r_or_seen   <= 1'b0;
                            r_trig_pend <= 1'b0;
                            r_post_p    <= w_post_p;
                        end
                    end
                    c_st_fill: begin
                        if (sample_en) begin
                            r_wr_ptr <= r_wr_ptr + c_one;
                            r_cnt    <= r_cnt + c_one;
                            if (r_cnt == w_pre_m1) begin
                                r_state <= c_st_wait;
                            end
                        end
                    end
                    c_st_wait: begin
                        if (w_edge) begin
                            r_trig_pend <= 1'b1;
                        end
                        if (sample_en) begin
                            r_wr_ptr <= r_wr_ptr + c_one;
                            if (r_trig_pend || w_edge) begin
                                r_trig_addr <= r_wr_ptr;
                                r_trig_pend <= 1'b0;
                                r_cnt       <= r_post_p - c_one;
                                r_state     <= (r_post_p == c_one) ? c_st_done : c_st_post;
                            end
                        end
                    end
                    c_st_post: begin
                        if (sample_en) begin
                            r_wr_ptr <= r_wr_ptr + c_one;
                            r_cnt    <= r_cnt - c_one;
                            if (r_cnt == c_one) begin
                                r_state <= c_st_done;
                            end
                        end
                    end
                    c_st_done: begin
                        // The write pointer now addresses the oldest sample of the frozen window.
                        if (rd_req) begin
                            r_state  <= c_st_read;
                            r_rd_ptr <= r_wr_ptr;
                            r_cnt    <= '0;
                        end
                    end
                    c_st_read: begin
                        if (rd_req) begin
                            r_rd_data  <= r_mem[r_rd_ptr];
                            r_rd_valid <= 1'b1;
                            r_rd_ptr   <= r_rd_ptr + c_one;
                            r_cnt      <= r_cnt + c_one;
                            if (r_cnt == c_ones) begin
                                r_rd_last <= 1'b1;
                                r_state   <= c_st_idle;
                            end
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign rd_last   = r_rd_last;
    assign state     = r_state;
    assign or_seen   = r_or_seen;
    assign trig_addr = r_trig_addr;

endmodule
`default_nettype wire

// File: tb/tb_oadc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_oadc_capture_ctrl
// Brief    : Scoreboard bench for oadc_capture_ctrl with a capture-window model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oadc_capture_ctrl;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] adc_data;
    logic              sample_en;
    logic              adc_or;
    logic              trig_in;
    logic              trig_pol;
    logic              arm;
    logic              abort;
    logic [ADDR_W-1:0] post_cnt;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic [2:0]        state;
    logic              or_seen;
    logic [ADDR_W-1:0] trig_addr;

    oadc_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .adc_data(adc_data), .sample_en(sample_en),
        .adc_or(adc_or), .trig_in(trig_in), .trig_pol(trig_pol), .arm(arm),
        .abort(abort), .post_cnt(post_cnt), .rd_req(rd_req), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_last(rd_last), .state(state), .or_seen(or_seen),
        .trig_addr(trig_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              last;
    } exp_t;

    exp_t              q_exp[$];
    logic [DATA_W-1:0] rec_d[$];
    int                exp_trig;
    bit                exp_or;
    logic              prev_trig;
    int                n_cmp = 0;
    int                n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every clock advance goes through here so the bench's trigger history stays aligned.
    task automatic cycle();
        @(posedge clk);
        prev_trig = rst ? 1'b0 : trig_in;
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                if (q_exp.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rd_unexpected: got data %0h with no read outstanding", rd_data);
                end else begin
                    e = q_exp.pop_front();
                    chk("rd_data", rd_data, e.d);
                    chk("rd_last", rd_last, e.last);
                    if (rd_last) chk("state_at_last", state, 0);
                end
            end
        end
    end

    // Runs one capture. Directed mode: one sample per cycle, value = index,
    // trigger raw level high for samples [t1, t1+3) and from t2 onward.
    task automatic capture(input int post, input logic pol, input bit directed,
                           input int t1, input int t2, input int or_at,
                           input bit rst_in_post);
        int  p, pre, n, rem, phase;
        bit  pend, edge_now, raw;
        p        = (post == 0) ? 1 : post;
        pre      = DEPTH - p;
        n        = 0;
        rem      = 0;
        phase    = 0;
        pend     = 0;
        exp_or   = 0;
        exp_trig = 0;
        rec_d.delete();
        trig_pol  = pol;
        post_cnt  = ADDR_W'(post);
        sample_en = 1'b0;
        if (directed) trig_in = pol;
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        chk("state_after_arm", state, 1);
        chk("or_clear_on_arm", or_seen, 0);
        for (int c = 0; c < 4000 && phase != 3; c++) begin
            if (directed) begin
                sample_en = 1'b1;
                adc_data  = DATA_W'(n);
                adc_or    = (n == or_at);
                raw       = (n >= t1 && n < t1 + 3) || (n >= t2);
                trig_in   = pol ? ~raw : raw;
            end else begin
                sample_en = ($urandom_range(0, 3) != 0);
                adc_data  = DATA_W'($urandom);
                adc_or    = ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 7) == 0) trig_in = ~trig_in;
            end
            edge_now = pol ? (!trig_in && prev_trig) : (trig_in && !prev_trig);
            if (rst_in_post && phase == 2) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
                sample_en = 1'b0;
                return;
            end
            if (phase == 0) begin
                if (sample_en) begin
                    rec_d.push_back(adc_data);
                    exp_or |= adc_or;
                    n++;
                    if (n == pre) phase = 1;
                end
            end else if (phase == 1) begin
                if (edge_now) pend = 1;
                if (sample_en) begin
                    rec_d.push_back(adc_data);
                    exp_or |= adc_or;
                    if (pend) begin
                        exp_trig = n % DEPTH;
                        rem      = p - 1;
                        phase    = (rem == 0) ? 3 : 2;
                    end
                    n++;
                end
            end else begin
                if (sample_en) begin
                    rec_d.push_back(adc_data);
                    exp_or |= adc_or;
                    n++;
                    rem--;
                    if (rem == 0) phase = 3;
                end
            end
            cycle();
        end
        sample_en = 1'b0;
        adc_or    = 1'b0;
        if (phase != 3) begin
            n_cmp++;
            n_bad++;
            $display("FAIL capture_timeout: model phase %0d, dut state %0d", phase, state);
            abort = 1'b1;
            cycle();
            abort = 1'b0;
            return;
        end
        chk("state_done", state, 4);
        chk("trig_addr", trig_addr, exp_trig);
        chk("or_seen", or_seen, exp_or);
        // Samples offered while frozen must not disturb the window.
        for (int i = 0; i < 3; i++) begin
            sample_en = 1'b1;
            adc_data  = DATA_W'($urandom);
            cycle();
        end
        sample_en = 1'b0;
        chk("state_frozen", state, 4);
    endtask

    task automatic readout(input int abort_at);
        int   reads, base;
        exp_t e;
        base   = rec_d.size() - DEPTH;
        rd_req = 1'b1;
        cycle();
        chk("state_read", state, 5);
        reads = 0;
        for (int c = 0; c < 2000 && reads < DEPTH; c++) begin
            if (abort_at >= 0 && reads == abort_at) begin
                abort  = 1'b1;
                rd_req = 1'b1;
                cycle();
                abort  = 1'b0;
                rd_req = 1'b0;
                chk("abort_rd_valid", rd_valid, 0);
                chk("abort_state", state, 0);
                chk("abort_or_hold", or_seen, exp_or);
                chk("abort_trig_hold", trig_addr, exp_trig);
                chk("abort_queue", q_exp.size(), 0);
                return;
            end
            rd_req = ($urandom_range(0, 3) != 0);
            if (rd_req) begin
                e.d    = rec_d[base + reads];
                e.last = (reads == DEPTH - 1);
                q_exp.push_back(e);
                reads++;
            end
            cycle();
        end
        rd_req = 1'b0;
        cycle();
        cycle();
        chk("state_after_read", state, 0);
        chk("rd_valid_idle", rd_valid, 0);
        chk("read_queue_drained", q_exp.size(), 0);
    endtask

    initial begin
        rst = 1'b1; adc_data = '0; sample_en = 1'b0; adc_or = 1'b0; trig_in = 1'b0;
        trig_pol = 1'b0; arm = 1'b0; abort = 1'b0; post_cnt = '0; rd_req = 1'b0;
        prev_trig = 1'b0;
        cycle();
        cycle();
        chk("rst_state", state, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_or_seen", or_seen, 0);
        chk("rst_trig_addr", trig_addr, 0);
        rst = 1'b0;
        cycle();

        // Rising edge on sample 20, four post samples.
        capture(4, 1'b0, 1, 1000, 20, -1, 0);
        chk("t1_trig_addr_const", trig_addr, 4);
        readout(-1);

        // Edge in FILL is discarded; edge at 14 triggers.
        capture(4, 1'b0, 1, 5, 14, -1, 0);
        chk("t2_trig_addr_const", trig_addr, 14);
        readout(-1);

        // Falling edge, post_cnt 0: FILL edge at 12 ignored, WAIT edge at 17 is sole sample.
        capture(0, 1'b1, 1, 12, 17, -1, 0);
        chk("t3_trig_addr_const", trig_addr, 1);
        readout(-1);

        // Overrange on sample 3 sticks through readout.
        capture(5, 1'b0, 1, 1000, 20, 3, 0);
        chk("t4_or_const", or_seen, 1);
        readout(-1);
        chk("t4_or_after_read", or_seen, 1);

        // arm and abort together in IDLE: abort wins.
        arm = 1'b1; abort = 1'b1;
        cycle();
        arm = 1'b0; abort = 1'b0;
        chk("arm_abort_idle", state, 0);

        // Abort during readout, then a fresh capture must arm.
        capture(3, 1'b0, 0, 0, 0, -1, 0);
        readout(4);
        capture(6, 1'b1, 0, 0, 0, -1, 0);
        readout(-1);

        // Reset in POST, then samples without arm are ignored.
        capture(8, 1'b0, 1, 1000, 20, 2, 1);
        chk("rst_post_state", state, 0);
        chk("rst_post_rd_valid", rd_valid, 0);
        chk("rst_post_rd_last", rd_last, 0);
        chk("rst_post_or", or_seen, 0);
        chk("rst_post_trig_addr", trig_addr, 0);
        chk("rst_post_rd_data", rd_data, 0);
        for (int i = 0; i < 5; i++) begin
            sample_en = 1'b1;
            adc_data  = DATA_W'($urandom);
            cycle();
            chk("idle_ignores_samples", state, 0);
        end
        sample_en = 1'b0;

        for (int i = 0; i < 8; i++) begin
            capture($urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)), 0, 0, 0, -1, 0);
            readout(-1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
